// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: types shared by the instruction fetch stage
// and its instruction buffer.
package i_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    localparam int MISS_CNT_W = 16;

    // Buffer entries are {pc, instr}: pc in the upper half.
    localparam int ENTRY_FIELDS = 2;

endpackage

// File: rtl/i_fetch_fifo.sv
// fetch_fifo: small instruction buffer between fetch and decode.
// Concurrent push/pop is honoured; flush wins over both.
module fetch_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd];

    assign w_do_pop  = pop & ~flush & ~empty;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push)
            r_mem[r_wr] <= din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + AW'(1);
            if (w_do_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Upstream must never push into a full buffer unless it drains too.
    a_no_overflow : assert property (
        @(posedge clock) disable iff (!reset_n)
        !(push && !flush && full && !pop)
    );

endmodule

// File: rtl/i_fetch.sv
// i_fetch: owns the PC, issues i_cache reads, holds them through
// misses and buffers {pc, instr} pairs for decode.
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               PC_INC     = 4,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    output logic [WIDTH-1:0]      address,
    output logic [WIDTH-1:0]      din,
    output logic                  rden,
    output logic                  wren,
    input  logic                  hit_miss,
    input  logic [WIDTH-1:0]      q,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [WIDTH-1:0]      inst_data,
    output logic [WIDTH-1:0]      inst_pc,
    output logic [MISS_CNT_W-1:0] miss_cycles
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ENTRY_FIELDS * WIDTH;

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [WIDTH-1:0]      r_pc;
    logic [MISS_CNT_W-1:0] r_miss;

    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_level;
    logic          w_space;
    logic          w_space_after;
    logic [DW-1:0] w_dout;

    assign w_pop  = inst_valid & inst_ready;
    assign w_push = (r_state == WAIT) & hit_miss & ~redirect_valid;

    // Occupancy once this cycle's pop has drained.
    assign w_level       = w_count - CW'(w_pop);
    assign w_space       = ~w_full | w_pop;
    assign w_space_after = (w_level + CW'(1)) < CW'(FIFO_DEPTH);

    always_comb begin
        w_next = r_state;
        if (redirect_valid) begin
            w_next = enable ? ISSUE : IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (enable && w_space)
                        w_next = ISSUE;
                end
                ISSUE: w_next = WAIT;
                WAIT: begin
                    if (hit_miss)
                        w_next = (enable && w_space_after) ? ISSUE : IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_miss  <= '0;
        end else begin
            r_state <= w_next;
            if (redirect_valid)
                r_pc <= redirect_pc;
            else if (w_push)
                r_pc <= r_pc + WIDTH'(PC_INC);
            if (r_state == WAIT && !hit_miss && r_miss != '1)
                r_miss <= r_miss + MISS_CNT_W'(1);
        end
    end

    fetch_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .din     ({r_pc, q}),
        .dout    (w_dout),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign address     = r_pc;
    assign din         = '0;
    assign wren        = 1'b0;
    assign rden        = (r_state != IDLE);
    assign inst_valid  = ~w_empty;
    assign inst_pc     = w_dout[DW-1:WIDTH];
    assign inst_data   = w_dout[WIDTH-1:0];
    assign miss_cycles = r_miss;

endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: scoreboard bench for i_fetch with a one-cycle
// i_cache model that can be told to miss N times.
module tb_i_fetch;
    localparam int W = 32;

    logic         clock          = 1'b0;
    logic         reset_n        = 1'b0;
    logic         enable         = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_pc    = '0;
    logic [W-1:0] address;
    logic [W-1:0] din;
    logic         rden;
    logic         wren;
    logic         hit_miss       = 1'b0;
    logic [W-1:0] q              = '0;
    logic         inst_valid;
    logic         inst_ready     = 1'b0;
    logic [W-1:0] inst_data;
    logic [W-1:0] inst_pc;
    logic [15:0]  miss_cycles;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int miss_left = 0;
    int pops      = 0;
    int t0;
    int pops0;

    logic [63:0] exp_q [$];
    int          pop_cyc [$];
    logic [63:0] e_exp;
    logic        s_rden;
    logic [W-1:0] s_addr;

    i_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .address        (address),
        .din            (din),
        .rden           (rden),
        .wren           (wren),
        .hit_miss       (hit_miss),
        .q              (q),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .miss_cycles    (miss_cycles)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        logic [3:0] n;
        n = a[5:2] + 4'd1;
        return {8{n}} ^ {a[W-1:6], 6'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    // Cache model: sample request away from the edge, answer next cycle.
    always @(negedge clock) begin
        s_rden = rden;
        s_addr = address;
    end

    always @(posedge clock) begin
        if (s_rden && miss_left > 0) begin
            hit_miss <= 1'b0;
            miss_left = miss_left - 1;
        end else if (s_rden) begin
            hit_miss <= 1'b1;
            q        <= mem_word(s_addr);
        end else begin
            hit_miss <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset_n && inst_valid && inst_ready) begin
            pops++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h_%h expected=none",
                         inst_pc, inst_data);
            end else begin
                e_exp = exp_q.pop_front();
                chk("pop_entry", {inst_pc, inst_data}, e_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        enable         = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        miss_left      = 0;
        tick(2);
        exp_q.delete();
        pop_cyc.delete();
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_rden", 64'(rden), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_data", 64'(inst_data), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);
        chk("rst_miss", 64'(miss_cycles), 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_din_wren", 64'({din, wren}), 64'd0);

        // Consecutive hits: latency 3, one instruction per 2 cycles
        exp_q.push_back({32'h0000_0000, 32'h1111_1111});
        exp_q.push_back({32'h0000_0004, 32'h2222_2222});
        inst_ready = 1'b1;
        enable     = 1'b1;
        t0         = cyc;
        tick(3);
        enable = 1'b0;
        tick(6);
        chk("s1_pops", 64'(pop_cyc.size()), 64'd2);
        if (pop_cyc.size() >= 2) begin
            chk("s1_latency", 64'(pop_cyc[0] - t0), 64'd3);
            chk("s1_spacing", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
        end
        chk("s1_addr", 64'(address), 64'h8);
        chk("s1_rden", 64'(rden), 64'd0);
        chk("s1_drained", 64'(exp_q.size()), 64'd0);

        // Five misses at address 4, then one hit
        do_reset();
        pops0     = pops;
        miss_left = 5;
        exp_q.push_back({32'h0000_0004, 32'h2222_2222});
        inst_ready     = 1'b1;
        redirect_pc    = 32'h0000_0004;
        redirect_valid = 1'b1;
        enable         = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        enable         = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("s2_hold", 64'({rden, address}), {31'd0, 1'b1, 32'h4});
        end
        tick(1);
        chk("s2_miss_cycles", 64'(miss_cycles), 64'd5);
        chk("s2_addr", 64'(address), 64'h8);
        tick(4);
        chk("s2_one_push", 64'(pops - pops0), 64'd1);
        chk("s2_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure fills the buffer, then fetch resumes at 16
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h1111_1111});
        exp_q.push_back({32'h0000_0004, 32'h2222_2222});
        exp_q.push_back({32'h0000_0008, 32'h3333_3333});
        exp_q.push_back({32'h0000_000C, 32'h4444_4444});
        exp_q.push_back({32'h0000_0010, 32'h5555_5555});
        enable = 1'b1;
        tick(12);
        chk("s3_full_rden", 64'(rden), 64'd0);
        chk("s3_full_addr", 64'(address), 64'h10);
        chk("s3_head", 64'({inst_valid, inst_pc}), {31'd0, 1'b1, 32'h0});
        inst_ready = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(8);
        chk("s3_drained", 64'(exp_q.size()), 64'd0);
        chk("s3_addr", 64'(address), 64'h14);

        // Redirect in WAIT coinciding with a hit flushes the buffer
        do_reset();
        enable = 1'b1;
        tick(4);
        redirect_pc    = 32'h1000_0004;
        redirect_valid = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        enable         = 1'b0;
        chk("s4_flushed", 64'(inst_valid), 64'd0);
        chk("s4_addr", 64'(address), 64'h1000_0004);
        chk("s4_rden", 64'(rden), 64'd1);
        exp_q.push_back({32'h1000_0004, 32'h3222_2222});
        inst_ready = 1'b1;
        tick(6);
        chk("s4_drained", 64'(exp_q.size()), 64'd0);
        chk("s4_next_addr", 64'(address), 64'h1000_0008);

        // PC wraps past the top of the address space
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFF_FFC0});
        redirect_pc    = 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        enable         = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        enable         = 1'b0;
        tick(5);
        chk("s5_wrap_addr", 64'(address), 64'h0);
        chk("s5_rden", 64'(rden), 64'd0);
        chk("s5_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a miss
        do_reset();
        miss_left = 100;
        enable    = 1'b1;
        tick(6);
        chk("s6_miss_cycles", 64'(miss_cycles), 64'd4);
        chk("s6_rden", 64'(rden), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_async", 64'({rden, inst_valid, miss_cycles}), 64'd0);
        chk("s6_addr", 64'(address), 64'h0);
        miss_left = 0;
        enable    = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("s6_idle", 64'(rden), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
